// File: rtl/bf_alu_pkg.sv
// Shared types for the Brainfuck CPU data-cell ALU: operation enum,
// default cell width and the select decoder.
package bf_pkg;

   localparam int BF_WIDTH = 8;

   typedef enum logic [1:0] {
      OP_NOP = 2'd0,
      OP_DEC = 2'd1,
      OP_INC = 2'd2,
      OP_ERR = 2'd3
   } bf_op_e;

   // Anything other than exactly one select high decodes to OP_ERR.
   function automatic bf_op_e bf_decode_op(input logic nochange,
                                           input logic decrement,
                                           input logic increment);
      bf_op_e op;
      case ({nochange, decrement, increment})
         3'b100:  op = OP_NOP;
         3'b010:  op = OP_DEC;
         3'b001:  op = OP_INC;
         default: op = OP_ERR;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/bf_alu_if.sv
// Bus between the datapath and the data-cell ALU.
// The slave modport is the ALU side; the master modport is the datapath side.
interface bf_alu_if
   import bf_pkg::*;
#(
   parameter int WIDTH = BF_WIDTH
);
   logic [WIDTH-1:0] a;
   logic             nochange;
   logic             decrement;
   logic             increment;
   logic [WIDTH-1:0] out;
   logic             zero;
   logic             wrap;
   logic             op_err;
   logic [WIDTH-1:0] out_q;
   logic             err_sticky;
   logic [15:0]      op_count;

   modport slave (
      input  a, nochange, decrement, increment,
      output out, zero, wrap, op_err, out_q, err_sticky, op_count
   );

   modport master (
      output a, nochange, decrement, increment,
      input  out, zero, wrap, op_err, out_q, err_sticky, op_count
   );
endinterface

// File: rtl/bf_alu_core.sv
// Purely combinational cell arithmetic: pass, decrement or increment, modulo 2**WIDTH.
// Wrap comes from the operand value, not from a carry out of a wider adder.
module bf_alu_core
   import bf_pkg::*;
#(
   parameter int WIDTH = BF_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  bf_op_e           op_i,
   output logic [WIDTH-1:0] out_o,
   output logic             zero_o,
   output logic             wrap_o
);
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] out_s;
   logic             wrap_s;

   // Result and wrap selection; error and nop both pass the operand through.
   always_comb begin
      out_s  = a_i;
      wrap_s = 1'b0;
      case (op_i)
         OP_INC: begin
            out_s  = a_i + ONE;
            wrap_s = &a_i;
         end
         OP_DEC: begin
            out_s  = a_i - ONE;
            wrap_s = ~|a_i;
         end
         default: begin
            out_s  = a_i;
            wrap_s = 1'b0;
         end
      endcase
   end

   assign out_o  = out_s;
   assign wrap_o = wrap_s;
   assign zero_o = (out_s == ZERO);

endmodule

// File: rtl/bf_alu.sv
// Data-cell ALU top: combinational core plus registered result, sticky
// select-error flag and an optional inc/dec counter enabled by BF_ALU_OPCNT_EN.
module bf_alu
   import bf_pkg::*;
#(
   parameter int WIDTH = BF_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   bf_alu_if.slave     bus
);
   bf_op_e           op_s;
   logic [WIDTH-1:0] out_s;
   logic             op_err_s;
   logic [WIDTH-1:0] res_q;
   logic             err_q;

   assign op_s     = bf_decode_op(bus.nochange, bus.decrement, bus.increment);
   assign op_err_s = (op_s == OP_ERR);

   bf_alu_core #(.WIDTH(WIDTH)) u_core (
      .a_i    (bus.a),
      .op_i   (op_s),
      .out_o  (out_s),
      .zero_o (bus.zero),
      .wrap_o (bus.wrap)
   );

   assign bus.out    = out_s;
   assign bus.op_err = op_err_s;

   // Result register and sticky error; the flag only clears through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= {WIDTH{1'b0}};
         err_q <= 1'b0;
      end else begin
         res_q <= out_s;
         err_q <= err_q | op_err_s;
      end
   end

   assign bus.out_q      = res_q;
   assign bus.err_sticky = err_q;

`ifdef BF_ALU_OPCNT_EN
   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Count only valid increments and decrements; wraps naturally at 16 bits.
   always_comb begin
      cnt_d = cnt_q;
      if (op_s == OP_INC || op_s == OP_DEC) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Operation counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.op_count = cnt_q;
`else
   assign bus.op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bf_alu.sv
// Directed self-checking bench for bf_alu; expected op_count follows BF_ALU_OPCNT_EN.
module tb_bf_alu;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   bf_alu_if #(.WIDTH(8)) bus ();

   bf_alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BF_ALU_OPCNT_EN
   localparam logic [15:0] CNT_AFTER_SEQ = 16'd5;
   localparam logic [15:0] CNT_AFTER_ONE = 16'd1;
`else
   localparam logic [15:0] CNT_AFTER_SEQ = 16'd0;
   localparam logic [15:0] CNT_AFTER_ONE = 16'd0;
`endif

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] a, input logic n, input logic d, input logic i);
      bus.a         = a;
      bus.nochange  = n;
      bus.decrement = d;
      bus.increment = i;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      #2;
      check("rst_out_q", {8'h00, bus.out_q}, 16'h0000);
      check("rst_err_sticky", {15'h0, bus.err_sticky}, 16'h0000);
      check("rst_op_count", bus.op_count, 16'h0000);

      // Combinational checks while registers are held in reset.
      drive(8'hAD, 1'b1, 1'b0, 1'b0); #1;
      check("nop_out", {8'h00, bus.out}, 16'h00AD);
      check("nop_zero", {15'h0, bus.zero}, 16'h0000);
      check("nop_wrap", {15'h0, bus.wrap}, 16'h0000);
      check("nop_err", {15'h0, bus.op_err}, 16'h0000);
      drive(8'hAD, 1'b0, 1'b1, 1'b0); #1;
      check("dec_out", {8'h00, bus.out}, 16'h00AC);
      drive(8'hAD, 1'b0, 1'b0, 1'b1); #1;
      check("inc_out", {8'h00, bus.out}, 16'h00AE);
      drive(8'hFE, 1'b0, 1'b0, 1'b1); #1;
      check("inc_fe_out", {8'h00, bus.out}, 16'h00FF);
      check("inc_fe_wrap", {15'h0, bus.wrap}, 16'h0000);
      drive(8'hFF, 1'b0, 1'b0, 1'b1); #1;
      check("inc_ff_out", {8'h00, bus.out}, 16'h0000);
      check("inc_ff_zero", {15'h0, bus.zero}, 16'h0001);
      check("inc_ff_wrap", {15'h0, bus.wrap}, 16'h0001);
      drive(8'h00, 1'b0, 1'b1, 1'b0); #1;
      check("dec_00_out", {8'h00, bus.out}, 16'h00FF);
      check("dec_00_wrap", {15'h0, bus.wrap}, 16'h0001);
      check("dec_00_zero", {15'h0, bus.zero}, 16'h0000);
      drive(8'h01, 1'b0, 1'b1, 1'b0); #1;
      check("dec_01_zero", {15'h0, bus.zero}, 16'h0001);
      check("dec_01_wrap", {15'h0, bus.wrap}, 16'h0000);
      drive(8'h10, 1'b0, 1'b0, 1'b0); #1;
      check("none_out", {8'h00, bus.out}, 16'h0010);
      check("none_err", {15'h0, bus.op_err}, 16'h0001);
      drive(8'h00, 1'b0, 1'b1, 1'b1); #1;
      check("multi00_out", {8'h00, bus.out}, 16'h0000);
      check("multi00_wrap", {15'h0, bus.wrap}, 16'h0000);
      check("multi00_err", {15'h0, bus.op_err}, 16'h0001);
      drive(8'hFF, 1'b1, 1'b1, 1'b1); #1;
      check("all3_out", {8'h00, bus.out}, 16'h00FF);
      check("all3_wrap", {15'h0, bus.wrap}, 16'h0000);
      check("rst_hold_err", {15'h0, bus.err_sticky}, 16'h0000);

      // Clocked sequence: 3 inc, 2 dec, 1 nop.
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         drive(8'(k), 1'b0, 1'b0, 1'b1);
         @(posedge clk); #1;
         check("seq_inc_out_q", {8'h00, bus.out_q}, 16'(k + 1));
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         drive(8'h10, 1'b0, 1'b1, 1'b0);
         @(posedge clk); #1;
         check("seq_dec_out_q", {8'h00, bus.out_q}, 16'h000F);
         @(negedge clk);
      end
      drive(8'h55, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("seq_nop_out_q", {8'h00, bus.out_q}, 16'h0055);
      check("seq_op_count", bus.op_count, CNT_AFTER_SEQ);
      check("seq_err_sticky", {15'h0, bus.err_sticky}, 16'h0000);

      // Illegal select pair sets the sticky flag, which survives a return to one-hot.
      @(negedge clk);
      drive(8'h42, 1'b0, 1'b1, 1'b1); #1;
      check("err_out", {8'h00, bus.out}, 16'h0042);
      check("err_op_err", {15'h0, bus.op_err}, 16'h0001);
      @(posedge clk); #1;
      check("err_sticky_set", {15'h0, bus.err_sticky}, 16'h0001);
      check("err_out_q", {8'h00, bus.out_q}, 16'h0042);
      check("err_op_count", bus.op_count, CNT_AFTER_SEQ);
      @(negedge clk);
      drive(8'h42, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("err_sticky_hold", {15'h0, bus.err_sticky}, 16'h0001);
      check("nop_op_count", bus.op_count, CNT_AFTER_SEQ);

      // Asynchronous reset between edges.
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      check("arst_out_q", {8'h00, bus.out_q}, 16'h0000);
      check("arst_err_sticky", {15'h0, bus.err_sticky}, 16'h0000);
      check("arst_op_count", bus.op_count, 16'h0000);
      check("arst_comb_out", {8'h00, bus.out}, 16'h0042);

      // Registers resume at the first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      drive(8'h07, 1'b0, 1'b0, 1'b1);
      @(posedge clk); #1;
      check("rel_out_q", {8'h00, bus.out_q}, 16'h0008);
      check("rel_op_count", bus.op_count, CNT_AFTER_ONE);
      check("rel_err_sticky", {15'h0, bus.err_sticky}, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
